sha_nonce_scheduler: RTL

- Dispatches a contiguous range of nonces across a pool of NUM_CORES SHA-256 pipelines (phase-2/phase-3 engines) and collects one 32-bit hash word per nonce.
- Sits between the bitcoin_hash top FSM and the core pool.
- Top pulses start with a base nonce, then drains results over a valid/ready port and receives a done pulse after the last result is accepted.

---
 rtl/sha_nonce_scheduler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sha_nonce_scheduler.sv
// ============================================================================
// Module   : sha_nonce_scheduler
// Brief    : Spreads a contiguous nonce range over NUM_CORES SHA-256 engines
//            and returns one hash word per nonce over a valid/ready port.
//            Optional early stop on target hit: SHA_SCHED_TARGET_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sha_nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            nonce_base,
  output logic [NUM_CORES-1:0]   core_start,
  output logic [32*NUM_CORES-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [32*NUM_CORES-1:0] core_hash,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [31:0]            res_nonce,
  output logic [31:0]            res_hash,
  output logic                   busy,
  output logic                   done
`ifdef SHA_SCHED_TARGET_EN
  ,
  input  logic [31:0]            target,
  output logic                   res_hit
`endif
);

  localparam int          IDX_W        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [16:0] C_NUM_NONCES = 17'(NUM_NONCES);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_FINISH} state_t;
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_HELD} core_st_t;

  state_t               state_q;
  core_st_t             cst_q   [NUM_CORES];
  logic [31:0]          nonce_q [NUM_CORES];
  logic [31:0]          hash_q  [NUM_CORES];
  logic [31:0]          base_q;
  logic [16:0]          issued_q, retired_q, limit_q;
  logic [16:0]          issued_d, retired_d, limit_d;
  logic [IDX_W-1:0]     ptr_q, lock_idx_q;
  logic                 lock_q;
  logic [NUM_CORES-1:0] core_start_q;
  logic                 busy_q, done_q;

  logic [NUM_CORES-1:0] w_held, w_idle;
  logic                 w_free, w_any_held, w_found;
  logic [IDX_W-1:0]     w_free_idx, w_rr_idx, w_sel, w_ptr_next;
  logic                 w_start_job, w_launch, w_accept, w_hit;
  logic [31:0]          w_launch_nonce;

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      w_held[c] = (cst_q[c] == C_HELD);
      w_idle[c] = (cst_q[c] == C_IDLE);
    end
  end

  always_comb begin
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      if (w_idle[c]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(c);
      end
    end
  end

  // Round-robin pick of a held slot, scanning upward from the pointer.
  always_comb begin
    logic [IDX_W-1:0] idx;
    w_rr_idx = '0;
    w_found  = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % NUM_CORES);
      if (!w_found && w_held[idx]) begin
        w_found  = 1'b1;
        w_rr_idx = idx;
      end
    end
  end

  assign w_any_held = |w_held;
  // A stalled presentation stays on the same slot even if an earlier slot fills.
  assign w_sel      = lock_q ? lock_idx_q : w_rr_idx;
  assign w_accept   = w_any_held & res_ready;
  assign w_ptr_next = (w_sel == IDX_W'(NUM_CORES - 1)) ? '0 : w_sel + IDX_W'(1);

  assign w_start_job    = (state_q == S_IDLE) && start;
  assign w_launch       = w_free && (w_start_job ||
                          (state_q == S_DISPATCH && issued_q < limit_q));
  assign w_launch_nonce = w_start_job ? nonce_base : base_q + 32'(issued_q);

`ifdef SHA_SCHED_TARGET_EN
  logic [31:0] target_q;
  assign w_hit   = w_any_held && (hash_q[w_sel] < target_q);
  assign res_hit = w_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            target_q <= '0;
    else if (w_start_job) target_q <= target;
  end
`else
  assign w_hit = 1'b0;
`endif

  always_comb begin
    issued_d  = issued_q + {16'd0, w_launch};
    retired_d = retired_q + {16'd0, w_accept};
    limit_d   = limit_q;
    if (state_q == S_DISPATCH && w_accept && w_hit) limit_d = issued_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      issued_q     <= '0;
      retired_q    <= '0;
      limit_q      <= '0;
      ptr_q        <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      core_start_q <= '0;
      done_q       <= 1'b0;
      if (w_launch) core_start_q <= NUM_CORES'(1) << w_free_idx;

      if (w_start_job) begin
        ptr_q  <= '0;
        lock_q <= 1'b0;
      end else begin
        lock_q     <= w_any_held & ~res_ready;
        lock_idx_q <= w_sel;
        if (w_accept) ptr_q <= w_ptr_next;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q    <= nonce_base;
            issued_q  <= 17'd1;
            retired_q <= '0;
            limit_q   <= C_NUM_NONCES;
            busy_q    <= 1'b1;
            state_q   <= (C_NUM_NONCES == 17'd1) ? S_DRAIN : S_DISPATCH;
          end
        end
        S_DISPATCH, S_DRAIN: begin
          issued_q  <= issued_d;
          retired_q <= retired_d;
          limit_q   <= limit_d;
          if (retired_d == limit_d) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (issued_d == limit_d) begin
            state_q <= S_DRAIN;
          end else begin
            state_q <= S_DISPATCH;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cst_q[c]   <= C_IDLE;
        nonce_q[c] <= '0;
        hash_q[c]  <= '0;
      end else if (w_launch && w_free_idx == IDX_W'(c)) begin
        cst_q[c]   <= C_RUN;
        nonce_q[c] <= w_launch_nonce;
      end else if (cst_q[c] == C_RUN && core_done[c]) begin
        cst_q[c]   <= C_HELD;
        hash_q[c]  <= core_hash[32*c +: 32];
      end else if (cst_q[c] == C_HELD && w_accept && w_sel == IDX_W'(c)) begin
        cst_q[c]   <= C_IDLE;
      end
    end

    assign core_nonce[32*c +: 32] = nonce_q[c];
  end

  assign core_start = core_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign res_valid  = w_any_held;
  assign res_nonce  = w_any_held ? nonce_q[w_sel] : 32'd0;
  assign res_hash   = w_any_held ? hash_q[w_sel]  : 32'd0;

endmodule

`default_nettype wire
